// File: rtl/button_pkg.sv
// Shared types for the button toggle bank: mode encodings,
// per-channel debounce FSM states and a counter-width helper.
package button_pkg;

    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_PEND   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_PEND = 2'b10
    } ch_state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: synchroniser, stable-count debounce FSM,
// debounced level and a registered one-cycle rise pulse.
import button_pkg::*;

module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic commit_rise_o,
    output logic rise_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    ch_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rise_q;

    logic s;
    logic d;
    logic commit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign d      = (state_q == PRESSED) || (state_q == RELEASE_PEND);
    assign commit = (s != d) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            rise_q <= commit && s;
            unique case (state_q)
                RELEASED, PRESS_PEND: begin
                    if (!s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (commit) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= PRESS_PEND;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                PRESSED, RELEASE_PEND: begin
                    if (s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (commit) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= RELEASE_PEND;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o       = d;
    assign commit_rise_o = commit && s;
    assign rise_o        = rise_q;

endmodule

// File: rtl/button_toggle_bank.sv
// N-channel debounced button bank with per-channel toggle/momentary output.
// Define BUTTON_LONG_PRESS_EN to add the long_press port and hold-to-cancel.
import button_pkg::*;

module button_toggle_bank #(
    parameter int N_CH              = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] mode,
    input  logic            clear,
    output logic [N_CH-1:0] stateful_button,
    output logic [N_CH-1:0] press_pulse
`ifdef BUTTON_LONG_PRESS_EN
    ,
    output logic [N_CH-1:0] long_press
`endif
);

    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] commit_rise;
    logic [N_CH-1:0] cancel;
    logic [N_CH-1:0] t_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_i        (button[i]),
            .level_o      (level[i]),
            .commit_rise_o(commit_rise[i]),
            .rise_o       (press_pulse[i])
        );
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q [N_CH];
    logic [N_CH-1:0]   long_fire;
    logic [N_CH-1:0]   long_q;

    always_comb begin
        long_fire = '0;
        cancel    = '0;
        for (int i = 0; i < N_CH; i++) begin
            long_fire[i] = level[i] && (hold_q[i] == HOLD_LAST);
            cancel[i]    = long_fire[i] && (mode[i] == MODE_TOGGLE);
        end
    end

    // Saturating hold counter fires exactly once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!level[i]) begin
                    hold_q[i] <= '0;
                end else if (hold_q[i] != HOLD_MAX) begin
                    hold_q[i] <= hold_q[i] + 1'b1;
                end
            end
            long_q <= long_fire;
        end
    end

    assign long_press = long_q;
`else
    assign cancel = '0;
`endif

    // Clear beats a same-edge press; the press pulse itself is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
        end else if (clear) begin
            t_q <= '0;
        end else begin
            t_q <= (t_q ^ commit_rise) & ~cancel;
        end
    end

    always_comb begin
        stateful_button = '0;
        for (int i = 0; i < N_CH; i++) begin
            stateful_button[i] = (mode[i] == MODE_MOMENTARY) ? level[i] : t_q[i];
        end
    end

endmodule
